acc_cpu_core: RTL



---
 rtl/acc_cpu_core.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/acc_cpu_core.sv
// Accumulator CPU: 16-word style internal RAM, 3-cycle FETCH/DECODE/EXEC sequencer.
// Optional single-step hold after each EXEC is enabled with `define ACC_CPU_STEP_EN (adds port step).
module acc_cpu_core #(
  parameter int WORDSIZE = 8,
  parameter int ADDR_W   = 4
) (
  input  logic                clk,
  input  logic                reset,
`ifdef ACC_CPU_STEP_EN
  input  logic                step,
`endif
  input  logic                start,
  input  logic                load_en,
  input  logic [ADDR_W-1:0]   load_addr,
  input  logic [WORDSIZE-1:0] load_data,
  output logic [WORDSIZE-1:0] acc,
  output logic [ADDR_W-1:0]   pc,
  output logic                busy,
  output logic                halted,
  output logic                zero,
  output logic                carry,
  output logic                err
);

  localparam int OPW   = WORDSIZE - ADDR_W;
  localparam int DEPTH = 1 << ADDR_W;

  localparam logic [OPW-1:0] OP_NOP  = OPW'(0);
  localparam logic [OPW-1:0] OP_LDA  = OPW'(1);
  localparam logic [OPW-1:0] OP_ADD  = OPW'(2);
  localparam logic [OPW-1:0] OP_SUB  = OPW'(3);
  localparam logic [OPW-1:0] OP_STA  = OPW'(4);
  localparam logic [OPW-1:0] OP_JMP  = OPW'(5);
  localparam logic [OPW-1:0] OP_JZ   = OPW'(6);
  localparam logic [OPW-1:0] OP_HALT = OPW'(7);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_HALT,
    ST_HOLD
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_W-1:0]     pc_q, pc_d;
  logic [WORDSIZE-1:0]   acc_q, acc_d;
  logic [WORDSIZE-1:0]   ir_q, ir_d;
  logic                  carry_q, carry_d;
  logic                  err_q, err_d;
  logic                  halted_q, halted_d;

  logic [WORDSIZE-1:0]   mem_q [DEPTH];
  logic [WORDSIZE-1:0]   rdata_q;
  logic [ADDR_W-1:0]     raddr;
  logic [ADDR_W-1:0]     waddr;
  logic [WORDSIZE-1:0]   wdata;
  logic                  mem_we;

  logic [OPW-1:0]        opcode;
  logic [ADDR_W-1:0]     operand;
  logic [WORDSIZE:0]     sum;

  assign opcode  = ir_q[WORDSIZE-1:ADDR_W];
  assign operand = ir_q[ADDR_W-1:0];
  assign sum     = {1'b0, acc_q} + {1'b0, rdata_q};

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latches).
    state_d  = state_q;
    pc_d     = pc_q;
    acc_d    = acc_q;
    ir_d     = ir_q;
    carry_d  = carry_q;
    err_d    = err_q;
    halted_d = halted_q;
    raddr    = pc_q;
    waddr    = load_addr;
    wdata    = load_data;
    mem_we   = 1'b0;

    case (state_q)
      ST_IDLE, ST_HALT: begin
        mem_we = load_en;
        if (start) begin
          state_d  = ST_FETCH;
          pc_d     = '0;
          err_d    = 1'b0;
          halted_d = 1'b0;
        end
      end
      ST_FETCH: begin
        raddr   = pc_q;
        state_d = ST_DECODE;
      end
      ST_DECODE: begin
        // The fetched word is on the RAM output now; launch the operand read from it directly.
        ir_d    = rdata_q;
        raddr   = rdata_q[ADDR_W-1:0];
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        pc_d = pc_q + ADDR_W'(1);
`ifdef ACC_CPU_STEP_EN
        state_d = ST_HOLD;
`else
        state_d = ST_FETCH;
`endif
        case (opcode)
          OP_NOP: ;
          OP_LDA: acc_d = rdata_q;
          OP_ADD: {carry_d, acc_d} = sum;
          OP_SUB: begin
            acc_d   = acc_q - rdata_q;
            carry_d = (acc_q < rdata_q);
          end
          OP_STA: begin
            mem_we = 1'b1;
            waddr  = operand;
            wdata  = acc_q;
          end
          OP_JMP: pc_d = operand;
          OP_JZ:  if (zero) pc_d = operand;
          OP_HALT: begin
            pc_d     = pc_q;
            halted_d = 1'b1;
            state_d  = ST_HALT;
          end
          default: begin
            pc_d     = pc_q;
            err_d    = 1'b1;
            halted_d = 1'b1;
            state_d  = ST_HALT;
          end
        endcase
      end
`ifdef ACC_CPU_STEP_EN
      ST_HOLD: if (step) state_d = ST_FETCH;
`endif
      default: state_d = ST_IDLE;
    endcase

    // Reset wins over any load or pending STA in the same cycle.
    if (reset) mem_we = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      pc_q     <= '0;
      acc_q    <= '0;
      ir_q     <= '0;
      carry_q  <= 1'b0;
      err_q    <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
      state_q  <= state_d;
      pc_q     <= pc_d;
      acc_q    <= acc_d;
      ir_q     <= ir_d;
      carry_q  <= carry_d;
      err_q    <= err_d;
      halted_q <= halted_d;
    end
  end

  // NOTE: the RAM array and its read register are deliberately not reset; program contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[waddr] <= wdata;
    rdata_q <= mem_q[raddr];
  end

  assign acc    = acc_q;
  assign pc     = pc_q;
  assign carry  = carry_q;
  assign err    = err_q;
  assign halted = halted_q;
  assign zero   = (acc_q == '0);
  assign busy   = (state_q == ST_FETCH) || (state_q == ST_DECODE) ||
                  (state_q == ST_EXEC)  || (state_q == ST_HOLD);

endmodule
